// File: rtl/sbr_rpt_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sbr_rpt_pkg: shared types, constants and parity helper for the SBR repeater |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package sbr_rpt_pkg;

  localparam logic [2:0] ISM_IDLE   = 3'b000;
  localparam int         SBR_PW_MAX = 32;

  typedef struct packed {
    logic                  np;
    logic                  pc;
    logic                  eom;
    logic [SBR_PW_MAX-1:0] payload;
    logic                  parity;
  } sbr_mst_bus_t;

  typedef struct packed {
    logic np;
    logic pc;
  } sbr_cup_t;

  // Even parity over eom and payload; zero-extended payload bits do not change it.
  function automatic logic sbr_parity(input logic eom, input logic [SBR_PW_MAX-1:0] payload);
    return ^{eom, payload};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sbr_rpt_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sbr_rpt_stage: one register stage of one sideband direction                 |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module sbr_rpt_stage
  import sbr_rpt_pkg::*;
#(
  parameter int PAYLOAD_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rep_rst,
  input  logic                     i_np,
  input  logic                     i_pc,
  input  logic                     i_eom,
  input  logic [PAYLOAD_WIDTH-1:0] i_payload,
  input  logic                     i_parity,
  input  logic [2:0]               i_ism,
  input  logic [1:0]               i_cup,
  output logic                     o_np,
  output logic                     o_pc,
  output logic                     o_eom,
  output logic [PAYLOAD_WIDTH-1:0] o_payload,
  output logic                     o_parity,
  output logic [2:0]               o_ism,
  output logic [1:0]               o_cup
);

  logic [6:0]               ctl_d, ctl_q;
  logic [PAYLOAD_WIDTH+1:0] dat_d, dat_q;

  // Control travels every cycle; data only moves while the companion ISM is awake.
  always_comb begin
    ctl_d = {i_np, i_pc, i_ism, i_cup};
    dat_d = dat_q;
    if (i_ism != ISM_IDLE) begin
      dat_d = {i_eom, i_payload, i_parity};
    end
  end

  always_ff @(posedge clk) begin
    if (rep_rst) begin
      ctl_q <= '0;
      dat_q <= '0;
    end else begin
      ctl_q <= ctl_d;
      dat_q <= dat_d;
    end
  end

  assign {o_np, o_pc, o_ism, o_cup}  = ctl_q;
  assign {o_eom, o_payload, o_parity} = dat_q;

endmodule
`default_nettype wire

// File: rtl/sbr_rpt_pipe_ccf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sbr_rpt_pipe_ccf: multi-stage sideband repeater, agent <-> SBR router       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module sbr_rpt_pipe_ccf
  import sbr_rpt_pkg::*;
#(
  parameter int PAYLOAD_WIDTH   = 8,
  parameter int NUM_STAGES      = 2,
  parameter int PARITY_REQUIRED = 0,
  parameter int IDLE_HOLD       = 4
) (
  input  logic                     clk,
  input  logic                     rep_rst,
  input  logic                     mnpput_agt,
  input  logic                     mpcput_agt,
  input  logic                     meom_agt,
  input  logic [PAYLOAD_WIDTH-1:0] mpayload_agt,
  input  logic                     mparity_agt,
  output logic                     mnpcup_agt,
  output logic                     mpccup_agt,
  output logic                     tnpput_agt,
  output logic                     tpcput_agt,
  output logic                     teom_agt,
  output logic [PAYLOAD_WIDTH-1:0] tpayload_agt,
  output logic                     tparity_agt,
  input  logic                     tnpcup_agt,
  input  logic                     tpccup_agt,
  input  logic [2:0]               side_ism_agent_agt,
  output logic [2:0]               side_ism_fabric_agt,
  input  logic                     pok_agt,
  output logic                     mnpput_rtr,
  output logic                     mpcput_rtr,
  output logic                     meom_rtr,
  output logic [PAYLOAD_WIDTH-1:0] mpayload_rtr,
  output logic                     mparity_rtr,
  input  logic                     mnpcup_rtr,
  input  logic                     mpccup_rtr,
  input  logic                     tnpput_rtr,
  input  logic                     tpcput_rtr,
  input  logic                     teom_rtr,
  input  logic [PAYLOAD_WIDTH-1:0] tpayload_rtr,
  input  logic                     tparity_rtr,
  output logic                     tnpcup_rtr,
  output logic                     tpccup_rtr,
  output logic [2:0]               side_ism_agent_rtr,
  input  logic [2:0]               side_ism_fabric_rtr,
  output logic                     pok_rtr,
  output logic                     clk_req,
  output logic                     par_err_agt,
  output logic                     par_err_rtr
);

  localparam logic [3:0] c_idle_hold = 4'(IDLE_HOLD);
  localparam logic       c_par_en    = (PARITY_REQUIRED != 0);

  // Index 0 is the chain input, index NUM_STAGES the chain output.
  logic [NUM_STAGES:0]                    w_m_np, w_m_pc, w_m_eom, w_m_par;
  logic [NUM_STAGES:0][PAYLOAD_WIDTH-1:0] w_m_pl;
  logic [NUM_STAGES:0][2:0]               w_m_ism;
  logic [NUM_STAGES:0][1:0]               w_m_cup;
  logic [NUM_STAGES:0]                    w_t_np, w_t_pc, w_t_eom, w_t_par;
  logic [NUM_STAGES:0][PAYLOAD_WIDTH-1:0] w_t_pl;
  logic [NUM_STAGES:0][2:0]               w_t_ism;
  logic [NUM_STAGES:0][1:0]               w_t_cup;

  sbr_cup_t w_tcup_in, w_mcup_in, w_tcup_out, w_mcup_out;

  // Target credits flow agent->router and ride the master-direction stages; master credits ride the target side.
  assign w_tcup_in  = '{np: tnpcup_agt, pc: tpccup_agt};
  assign w_mcup_in  = '{np: mnpcup_rtr, pc: mpccup_rtr};

  assign w_m_np[0]  = mnpput_agt;
  assign w_m_pc[0]  = mpcput_agt;
  assign w_m_eom[0] = meom_agt;
  assign w_m_pl[0]  = mpayload_agt;
  assign w_m_par[0] = c_par_en ? mparity_agt : 1'b0;
  assign w_m_ism[0] = side_ism_agent_agt;
  assign w_m_cup[0] = w_tcup_in;

  assign w_t_np[0]  = tnpput_rtr;
  assign w_t_pc[0]  = tpcput_rtr;
  assign w_t_eom[0] = teom_rtr;
  assign w_t_pl[0]  = tpayload_rtr;
  assign w_t_par[0] = c_par_en ? tparity_rtr : 1'b0;
  assign w_t_ism[0] = side_ism_fabric_rtr;
  assign w_t_cup[0] = w_mcup_in;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    sbr_rpt_stage #(.PAYLOAD_WIDTH(PAYLOAD_WIDTH)) u_mst (
      .clk       (clk),
      .rep_rst   (rep_rst),
      .i_np      (w_m_np[k]),
      .i_pc      (w_m_pc[k]),
      .i_eom     (w_m_eom[k]),
      .i_payload (w_m_pl[k]),
      .i_parity  (w_m_par[k]),
      .i_ism     (w_m_ism[k]),
      .i_cup     (w_m_cup[k]),
      .o_np      (w_m_np[k+1]),
      .o_pc      (w_m_pc[k+1]),
      .o_eom     (w_m_eom[k+1]),
      .o_payload (w_m_pl[k+1]),
      .o_parity  (w_m_par[k+1]),
      .o_ism     (w_m_ism[k+1]),
      .o_cup     (w_m_cup[k+1])
    );

    sbr_rpt_stage #(.PAYLOAD_WIDTH(PAYLOAD_WIDTH)) u_tgt (
      .clk       (clk),
      .rep_rst   (rep_rst),
      .i_np      (w_t_np[k]),
      .i_pc      (w_t_pc[k]),
      .i_eom     (w_t_eom[k]),
      .i_payload (w_t_pl[k]),
      .i_parity  (w_t_par[k]),
      .i_ism     (w_t_ism[k]),
      .i_cup     (w_t_cup[k]),
      .o_np      (w_t_np[k+1]),
      .o_pc      (w_t_pc[k+1]),
      .o_eom     (w_t_eom[k+1]),
      .o_payload (w_t_pl[k+1]),
      .o_parity  (w_t_par[k+1]),
      .o_ism     (w_t_ism[k+1]),
      .o_cup     (w_t_cup[k+1])
    );
  end

  assign w_tcup_out = w_m_cup[NUM_STAGES];
  assign w_mcup_out = w_t_cup[NUM_STAGES];

  assign mnpput_rtr          = w_m_np[NUM_STAGES];
  assign mpcput_rtr          = w_m_pc[NUM_STAGES];
  assign meom_rtr            = w_m_eom[NUM_STAGES];
  assign mpayload_rtr        = w_m_pl[NUM_STAGES];
  assign mparity_rtr         = c_par_en ? w_m_par[NUM_STAGES] : 1'b0;
  assign side_ism_agent_rtr  = w_m_ism[NUM_STAGES];
  assign tnpcup_rtr          = w_tcup_out.np;
  assign tpccup_rtr          = w_tcup_out.pc;

  assign tnpput_agt          = w_t_np[NUM_STAGES];
  assign tpcput_agt          = w_t_pc[NUM_STAGES];
  assign teom_agt            = w_t_eom[NUM_STAGES];
  assign tpayload_agt        = w_t_pl[NUM_STAGES];
  assign tparity_agt         = c_par_en ? w_t_par[NUM_STAGES] : 1'b0;
  assign side_ism_fabric_agt = w_t_ism[NUM_STAGES];
  assign mnpcup_agt          = w_mcup_out.np;
  assign mpccup_agt          = w_mcup_out.pc;

  logic [NUM_STAGES-1:0] pok_d, pok_q;
  logic [3:0]            hold_cnt_d, hold_cnt_q;
  logic                  par_err_agt_d, par_err_agt_q;
  logic                  par_err_rtr_d, par_err_rtr_q;
  logic                  w_activity;
  sbr_mst_bus_t          w_m_bus, w_t_bus;

  assign pok_d   = NUM_STAGES'({pok_q, pok_agt});
  assign pok_rtr = pok_q[NUM_STAGES-1];

  always_comb begin
    w_m_bus         = '0;
    w_m_bus.np      = mnpput_agt;
    w_m_bus.pc      = mpcput_agt;
    w_m_bus.eom     = meom_agt;
    w_m_bus.payload = SBR_PW_MAX'(mpayload_agt);
    w_m_bus.parity  = mparity_agt;
    w_t_bus         = '0;
    w_t_bus.np      = tnpput_rtr;
    w_t_bus.pc      = tpcput_rtr;
    w_t_bus.eom     = teom_rtr;
    w_t_bus.payload = SBR_PW_MAX'(tpayload_rtr);
    w_t_bus.parity  = tparity_rtr;

    par_err_agt_d = par_err_agt_q;
    par_err_rtr_d = par_err_rtr_q;
    if (c_par_en && (w_m_bus.np || w_m_bus.pc) &&
        (w_m_bus.parity != sbr_parity(w_m_bus.eom, w_m_bus.payload))) begin
      par_err_agt_d = 1'b1;
    end
    if (c_par_en && (w_t_bus.np || w_t_bus.pc) &&
        (w_t_bus.parity != sbr_parity(w_t_bus.eom, w_t_bus.payload))) begin
      par_err_rtr_d = 1'b1;
    end
  end

  // Anything awake at the inputs or still in flight inside the pipe keeps the clock requested.
  always_comb begin
    w_activity = (side_ism_agent_agt != ISM_IDLE) || (side_ism_fabric_rtr != ISM_IDLE);
    for (int k = 1; k <= NUM_STAGES; k++) begin
      w_activity = w_activity | (w_m_ism[k] != ISM_IDLE) | (w_t_ism[k] != ISM_IDLE) |
                   w_m_np[k] | w_m_pc[k] | w_t_np[k] | w_t_pc[k];
    end
    hold_cnt_d = hold_cnt_q;
    if (w_activity) begin
      hold_cnt_d = c_idle_hold;
    end else if (hold_cnt_q != 4'd0) begin
      hold_cnt_d = hold_cnt_q - 4'd1;
    end
  end

  assign clk_req     = w_activity | (hold_cnt_q != 4'd0);
  assign par_err_agt = par_err_agt_q;
  assign par_err_rtr = par_err_rtr_q;

  always_ff @(posedge clk) begin
    if (rep_rst) begin
      pok_q         <= '0;
      hold_cnt_q    <= '0;
      par_err_agt_q <= 1'b0;
      par_err_rtr_q <= 1'b0;
    end else begin
      pok_q         <= pok_d;
      hold_cnt_q    <= hold_cnt_d;
      par_err_agt_q <= par_err_agt_d;
      par_err_rtr_q <= par_err_rtr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sbr_rpt_pipe_ccf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sbr_rpt_pipe_ccf: random-stimulus bench with a history-based model       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_sbr_rpt_pipe_ccf;

  localparam int NS   = 3;
  localparam int PW   = 8;
  localparam int IH   = 4;
  localparam int NCYC = 800;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rep_rst;
  logic          mnpput_agt, mpcput_agt, meom_agt, mparity_agt;
  logic [PW-1:0] mpayload_agt;
  logic          mnpcup_agt, mpccup_agt;
  logic          tnpput_agt, tpcput_agt, teom_agt, tparity_agt;
  logic [PW-1:0] tpayload_agt;
  logic          tnpcup_agt, tpccup_agt;
  logic [2:0]    side_ism_agent_agt, side_ism_fabric_agt;
  logic          pok_agt;
  logic          mnpput_rtr, mpcput_rtr, meom_rtr, mparity_rtr;
  logic [PW-1:0] mpayload_rtr;
  logic          mnpcup_rtr, mpccup_rtr;
  logic          tnpput_rtr, tpcput_rtr, teom_rtr, tparity_rtr;
  logic [PW-1:0] tpayload_rtr;
  logic          tnpcup_rtr, tpccup_rtr;
  logic [2:0]    side_ism_agent_rtr, side_ism_fabric_rtr;
  logic          pok_rtr, clk_req, par_err_agt, par_err_rtr;

  sbr_rpt_pipe_ccf #(
    .PAYLOAD_WIDTH(PW), .NUM_STAGES(NS), .PARITY_REQUIRED(1), .IDLE_HOLD(IH)
  ) dut (
    .clk(clk), .rep_rst(rep_rst),
    .mnpput_agt(mnpput_agt), .mpcput_agt(mpcput_agt), .meom_agt(meom_agt),
    .mpayload_agt(mpayload_agt), .mparity_agt(mparity_agt),
    .mnpcup_agt(mnpcup_agt), .mpccup_agt(mpccup_agt),
    .tnpput_agt(tnpput_agt), .tpcput_agt(tpcput_agt), .teom_agt(teom_agt),
    .tpayload_agt(tpayload_agt), .tparity_agt(tparity_agt),
    .tnpcup_agt(tnpcup_agt), .tpccup_agt(tpccup_agt),
    .side_ism_agent_agt(side_ism_agent_agt), .side_ism_fabric_agt(side_ism_fabric_agt),
    .pok_agt(pok_agt),
    .mnpput_rtr(mnpput_rtr), .mpcput_rtr(mpcput_rtr), .meom_rtr(meom_rtr),
    .mpayload_rtr(mpayload_rtr), .mparity_rtr(mparity_rtr),
    .mnpcup_rtr(mnpcup_rtr), .mpccup_rtr(mpccup_rtr),
    .tnpput_rtr(tnpput_rtr), .tpcput_rtr(tpcput_rtr), .teom_rtr(teom_rtr),
    .tpayload_rtr(tpayload_rtr), .tparity_rtr(tparity_rtr),
    .tnpcup_rtr(tnpcup_rtr), .tpccup_rtr(tpccup_rtr),
    .side_ism_agent_rtr(side_ism_agent_rtr), .side_ism_fabric_rtr(side_ism_fabric_rtr),
    .pok_rtr(pok_rtr), .clk_req(clk_req),
    .par_err_agt(par_err_agt), .par_err_rtr(par_err_rtr)
  );

  // One cycle of stimulus; z marks history slots wiped by a reset.
  typedef struct packed {
    logic          rst;
    logic          mnp, mpc, meom;
    logic [PW-1:0] mpl;
    logic          mpar;
    logic          tnp, tpc, teom;
    logic [PW-1:0] tpl;
    logic          tpar;
    logic          mnpcup, mpccup, tnpcup, tpccup;
    logic [2:0]    isma, ismf;
    logic          pok;
    logic          z;
  } stim_t;

  stim_t hs [NCYC];
  logic  act_arr [NCYC];
  int    checks   = 0;
  int    failures = 0;
  int    cyc      = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic stim_t at(input int j);
    if (j < 0) return '0;
    return hs[j];
  endfunction

  // Latest {eom,payload,parity} sent with a non-IDLE ISM at or before cycle n, zero across a reset.
  function automatic logic [PW+1:0] m_dat(input int n);
    for (int j = n; j >= 0; j--) begin
      if (hs[j].z) return '0;
      if (hs[j].isma != 3'b000) return {hs[j].meom, hs[j].mpl, hs[j].mpar};
    end
    return '0;
  endfunction

  function automatic logic [PW+1:0] t_dat(input int n);
    for (int j = n; j >= 0; j--) begin
      if (hs[j].z) return '0;
      if (hs[j].ismf != 3'b000) return {hs[j].teom, hs[j].tpl, hs[j].tpar};
    end
    return '0;
  endfunction

  function automatic stim_t gen(input int i);
    stim_t s;
    logic  idle;
    s    = '0;
    idle = (i % 120) >= 100;
    if (!idle) begin
      s.rst    = (i % 150 == 75) || ($urandom_range(0, 99) == 0);
      s.isma   = ($urandom_range(0, 9) < 3) ? 3'b000 : 3'($urandom_range(1, 7));
      s.ismf   = ($urandom_range(0, 9) < 3) ? 3'b000 : 3'($urandom_range(1, 7));
      s.mnp    = ($urandom_range(0, 3) == 0);
      s.mpc    = ($urandom_range(0, 3) == 0);
      s.tnp    = ($urandom_range(0, 3) == 0);
      s.tpc    = ($urandom_range(0, 3) == 0);
      s.meom   = 1'($urandom_range(0, 1));
      s.teom   = 1'($urandom_range(0, 1));
      s.mpl    = PW'($urandom);
      s.tpl    = PW'($urandom);
      s.mpar   = (^{s.meom, s.mpl}) ^ ($urandom_range(0, 19) == 0);
      s.tpar   = (^{s.teom, s.tpl}) ^ ($urandom_range(0, 19) == 0);
      s.mnpcup = 1'($urandom_range(0, 1));
      s.mpccup = 1'($urandom_range(0, 1));
      s.tnpcup = 1'($urandom_range(0, 1));
      s.tpccup = 1'($urandom_range(0, 1));
      s.pok    = ($urandom_range(0, 9) != 0);
    end
    return s;
  endfunction

  task automatic apply(input stim_t s);
    rep_rst             = s.rst;
    mnpput_agt          = s.mnp;
    mpcput_agt          = s.mpc;
    meom_agt            = s.meom;
    mpayload_agt        = s.mpl;
    mparity_agt         = s.mpar;
    tnpput_rtr          = s.tnp;
    tpcput_rtr          = s.tpc;
    teom_rtr            = s.teom;
    tpayload_rtr        = s.tpl;
    tparity_rtr         = s.tpar;
    mnpcup_rtr          = s.mnpcup;
    mpccup_rtr          = s.mpccup;
    tnpcup_agt          = s.tnpcup;
    tpccup_agt          = s.tpccup;
    side_ism_agent_agt  = s.isma;
    side_ism_fabric_rtr = s.ismf;
    pok_agt             = s.pok;
  endtask

  stim_t s, e, p;
  logic  err_a, err_r, a, exp_req;
  int    last_rst;

  initial begin
    s = '0;
    apply(s);
    rep_rst = 1'b1;
    repeat (3) @(negedge clk);
    rep_rst = 1'b0;
    #1;
    chk("reset_state",
        {mnpput_rtr, mpcput_rtr, meom_rtr, mpayload_rtr, mparity_rtr, mnpcup_agt, mpccup_agt,
         tnpput_agt, tpcput_agt, teom_agt, tpayload_agt, tparity_agt, tnpcup_rtr, tpccup_rtr,
         side_ism_agent_rtr, side_ism_fabric_agt, pok_rtr, clk_req, par_err_agt, par_err_rtr},
        64'd0);
    @(negedge clk);

    err_a    = 1'b0;
    err_r    = 1'b0;
    last_rst = -1;
    for (int i = 0; i < NCYC; i++) begin
      cyc    = i;
      s      = gen(i);
      hs[i]  = s;
      apply(s);
      #1;

      e = at(i - NS);
      chk("m_put",   {mnpput_rtr, mpcput_rtr}, {e.mnp, e.mpc});
      chk("m_data",  {meom_rtr, mpayload_rtr, mparity_rtr}, m_dat(i - NS));
      chk("t_put",   {tnpput_agt, tpcput_agt}, {e.tnp, e.tpc});
      chk("t_data",  {teom_agt, tpayload_agt, tparity_agt}, t_dat(i - NS));
      chk("m_cup",   {mnpcup_agt, mpccup_agt}, {e.mnpcup, e.mpccup});
      chk("t_cup",   {tnpcup_rtr, tpccup_rtr}, {e.tnpcup, e.tpccup});
      chk("ism_agt", side_ism_agent_rtr, e.isma);
      chk("ism_fab", side_ism_fabric_agt, e.ismf);
      chk("pok",     pok_rtr, e.pok);
      chk("par_err_agt", par_err_agt, err_a);
      chk("par_err_rtr", par_err_rtr, err_r);

      a = (s.isma != 3'b000) || (s.ismf != 3'b000);
      for (int k = 1; k <= NS; k++) begin
        p = at(i - k);
        a = a | (p.isma != 3'b000) | (p.ismf != 3'b000) | p.mnp | p.mpc | p.tnp | p.tpc;
      end
      act_arr[i] = a;
      exp_req    = a;
      for (int j = i - IH; j < i; j++) begin
        if (j >= 0 && j > last_rst && act_arr[j]) exp_req = 1'b1;
      end
      chk("clk_req", clk_req, exp_req);

      if (s.rst) begin
        err_a    = 1'b0;
        err_r    = 1'b0;
        last_rst = i;
        for (int k = 0; k < NS; k++) begin
          if (i - k >= 0) begin
            hs[i-k]   = '0;
            hs[i-k].z = 1'b1;
          end
        end
      end else begin
        if ((s.mnp || s.mpc) && (s.mpar != ^{s.meom, s.mpl})) err_a = 1'b1;
        if ((s.tnp || s.tpc) && (s.tpar != ^{s.teom, s.tpl})) err_r = 1'b1;
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
